ahb_mem_arbiter: RTL
====================

Name: ahb_mem_arbiter

Overview:
- Shares the single AHB/SPM memory controller port between two requesters: the data path (LSU, load/store) and the instruction fetch unit (IFU, read only).
- Sits between the requesters and the memory controller's memory_rd_en/memory_wr_en/memory_addr interface.
- Issues one access at a time and tracks its completion, whether it is an SPM access (1 cycle) or an AHB access (ends on trans_end_en).
- Returns the read data, an ack pulse and an error flag to the owning requester; includes a starvation guard and a timeout watchdog.

Parameters:
STARVE_LIMIT, 4, consecutive LSU grants allowed while IFU is pending before IFU is forced through (1..15)
TIMEOUT_CYCLES, 255, maximum AHB wait cycles before the access is aborted with an error (1..255)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
lsu_req  input  1  LSU access request; held with its fields stable until lsu_ack
lsu_wr  input  1  1 = store, 0 = load
lsu_addr  input  32  LSU byte address
lsu_wdata  input  32  store data
lsu_byteena  input  4  store byte enables
lsu_ack  output  1  one-cycle completion pulse to LSU
lsu_err  output  1  valid with lsu_ack; access failed
ifu_req  input  1  fetch request; held with ifu_addr stable until ifu_ack
ifu_addr  input  32  fetch address
ifu_ack  output  1  one-cycle completion pulse to IFU
ifu_err  output  1  valid with ifu_ack; fetch failed
rd_data  output  32  read data, valid with either ack
memory_rd_en  output  1  to memory controller
memory_wr_en  output  1  to memory controller
memory_addr  output  32  to memory controller
store_data  output  32  to memory controller
store_byteena  output  4  to memory controller
bus_spm_enable  input  1  from memory controller; the issued access targets SPM
trans_end_en  input  1  from memory controller; AHB transfer completes this cycle
load_rd_data  input  32  from memory controller
bus_err  input  1  memory controller exception code not equal to ISA_EXP_NO_EXP (AHB error)

Behaviour:
- States: IDLE, AHB_WAIT, SPM_RESP. Registers: owner (0 = LSU, 1 = IFU), starve_cnt (4b), wd_cnt (8b).
- Reset: state IDLE, owner 0, counters 0. All outputs are 0 during reset and in IDLE with no request.
- IDLE, arbitration (combinational, same cycle):
  - If only one request is pending, that requester wins.
  - If both are pending, LSU wins unless starve_cnt == STARVE_LIMIT, in which case IFU wins.
- Issue (IDLE with a winner): for exactly one cycle, drive
  - memory_rd_en = (winner is IFU) or !lsu_wr
  - memory_wr_en = (winner is LSU) and lsu_wr
  - memory_addr = winner address
  - store_data / store_byteena = LSU fields if LSU wins, else 0
  - Latch owner and clear wd_cnt. Next state is SPM_RESP if bus_spm_enable, else AHB_WAIT.
  - In every cycle other than issue, memory_rd_en, memory_wr_en, memory_addr, store_data and store_byteena are all 0.
- SPM_RESP: 1 cycle. Owner's ack = 1, err = 0, rd_data = load_rd_data. Next state IDLE.
- AHB_WAIT:
  - On trans_end_en: owner's ack = 1, err = bus_err, rd_data = load_rd_data (0 for stores is acceptable). Next state IDLE.
  - Otherwise wd_cnt increments. When wd_cnt == TIMEOUT_CYCLES-1 with no trans_end_en, owner's ack = 1, err = 1, rd_data = 0, next state IDLE.
  - A trans_end_en arriving in IDLE after an abort is ignored; no ack is produced.
- Latency:
  - SPM access: issue at cycle N, ack at N+1.
  - AHB access: ack in the trans_end_en cycle.
  - Minimum one IDLE cycle between accesses (ack cycle, then issue in the following cycle).
- Starvation counter, updated on each issue:
  - LSU issued while ifu_req = 1: starve_cnt increments, saturating at STARVE_LIMIT.
  - IFU issued, or ifu_req = 0 at issue: starve_cnt clears to 0.
- Boundaries:
  - A request deasserted before its ack is a protocol violation; the arbiter still completes and acks the latched owner.
  - Both acks never assert in the same cycle.
  - Requests arriving during AHB_WAIT or SPM_RESP wait in IDLE arbitration.
  - Reset mid-transfer drops the access with no ack.

Test Plan:
- LSU load 0x0000_1000, AHB, slave trans_end_en 3 cycles after issue with load_rd_data=0xDEADBEEF -> single-cycle memory_rd_en=1, addr 0x1000; lsu_ack=1, lsu_err=0, rd_data=0xDEADBEEF in the end cycle; ifu_ack stays 0.
- IFU fetch where bus_spm_enable=1 at issue and load_rd_data=0x00000013 next cycle -> ifu_ack at issue+1 with rd_data=0x13; no dependency on trans_end_en.
- Both requesting continuously, all accesses SPM, STARVE_LIMIT=4 -> grant order LSU,LSU,LSU,LSU,IFU,LSU,... with each issue separated by one ack cycle.
- LSU store 0xA5A5A5A5, byteena 4'b0011 -> single-cycle memory_wr_en=1, store_data=0xA5A5A5A5, store_byteena=0011; trans_end_en with bus_err=1 -> lsu_ack=1, lsu_err=1.
- AHB read with no trans_end_en, TIMEOUT_CYCLES=8 -> owner ack with err=1 exactly 8 cycles after issue; a later stray trans_end_en produces no ack.
- rst_n asserted low during AHB_WAIT -> all outputs 0 immediately, state IDLE, no ack after release until a new request is made.

Source files
------------

// File: rtl/ahb_mem_arbiter.sv
// Shares the memory controller port between the LSU and the IFU: one access
// in flight at a time, completed via SPM (1 cycle) or AHB (trans_end_en / watchdog).
module ahb_mem_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_req,
    input  logic        lsu_wr,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_byteena,
    output logic        lsu_ack,
    output logic        lsu_err,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_ack,
    output logic        ifu_err,
    output logic [31:0] rd_data,
    output logic        memory_rd_en,
    output logic        memory_wr_en,
    output logic [31:0] memory_addr,
    output logic [31:0] store_data,
    output logic [3:0]  store_byteena,
    input  logic        bus_spm_enable,
    input  logic        trans_end_en,
    input  logic [31:0] load_rd_data,
    input  logic        bus_err
);
    localparam logic [3:0] LIM     = 4'(STARVE_LIMIT);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, AHB_WAIT = 2'd1, SPM_RESP = 2'd2} state_e;

    state_e      state_q;
    logic        owner_q;      // 0 = LSU, 1 = IFU
    logic [3:0]  starve_q;
    logic [7:0]  wd_q;
    logic        live_q;       // keeps issue outputs quiet until the first edge after reset

    logic pick_ifu, issue, ahb_end, timeout, done, err_now;

    assign pick_ifu = ifu_req & (~lsu_req | (starve_q == LIM));
    assign issue    = live_q & (state_q == IDLE) & (lsu_req | ifu_req);
    assign ahb_end  = (state_q == AHB_WAIT) & trans_end_en;
    assign timeout  = (state_q == AHB_WAIT) & ~trans_end_en & (wd_q == TO_LAST);
    assign done     = (state_q == SPM_RESP) | ahb_end | timeout;
    assign err_now  = timeout | (ahb_end & bus_err);

    assign memory_rd_en  = issue & (pick_ifu | ~lsu_wr);
    assign memory_wr_en  = issue & ~pick_ifu & lsu_wr;
    assign memory_addr   = issue ? (pick_ifu ? ifu_addr : lsu_addr) : 32'd0;
    assign store_data    = (issue & ~pick_ifu) ? lsu_wdata : 32'd0;
    assign store_byteena = (issue & ~pick_ifu) ? lsu_byteena : 4'd0;

    assign lsu_ack = done & ~owner_q;
    assign ifu_ack = done & owner_q;
    assign lsu_err = lsu_ack & err_now;
    assign ifu_err = ifu_ack & err_now;
    assign rd_data = (done & ~timeout) ? load_rd_data : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            starve_q <= 4'd0;
            wd_q     <= 8'd0;
            live_q   <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        owner_q <= pick_ifu;
                        wd_q    <= 8'd0;
                        state_q <= bus_spm_enable ? SPM_RESP : AHB_WAIT;
                        // count LSU wins that made a waiting IFU sit out
                        if (!pick_ifu && ifu_req)
                            starve_q <= (starve_q == LIM) ? LIM : starve_q + 4'd1;
                        else
                            starve_q <= 4'd0;
                    end
                end
                AHB_WAIT: begin
                    if (trans_end_en || timeout) state_q <= IDLE;
                    else                         wd_q    <= wd_q + 8'd1;
                end
                SPM_RESP: state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end
endmodule
